axil_multi_adder: RTL and testbench

AXI4-Lite slave holding NUM_CH independent adder channels, each with two writable operands and a read-only registered sum and status word.
- Parametrised successor to the single-adder memory-mapped slave. Adds configurable channel count, per-byte write strobes, 2-bit OKAY/SLVERR responses and address decoding with error reporting.
- Sits on the s1 AXI4-Lite interconnect port.

---
 rtl/axil_multi_adder.sv | 219 +++++++++++++++++++++
 tb/tb_axil_multi_adder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/axil_multi_adder.sv
// AXI4-Lite slave with NUM_CH registered adders (OPA, OPB, RESULT, STATUS).
// Define AXIL_ADDER_SAT_EN to saturate RESULT on carry-out.
module axil_multi_adder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CH     = 4
) (
  input  logic                    s1_axi_aclk,
  input  logic                    s1_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [1:0]              s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [1:0]              s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = ADDR_WIDTH - 4;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } wst_t;
  typedef enum logic { R_IDLE, R_DATA } rst_t;

  wst_t wst_q;
  rst_t rst_q;

  logic [DATA_WIDTH-1:0] opa_q [NUM_CH];
  logic [DATA_WIDTH-1:0] opb_q [NUM_CH];
  logic [DATA_WIDTH-1:0] res_q [NUM_CH];
  logic [DATA_WIDTH-1:0] res_d [NUM_CH];
  logic [2:0]            sts_q [NUM_CH];
  logic [2:0]            sts_d [NUM_CH];
  logic [DATA_WIDTH:0]   full_d [NUM_CH];

  logic                  awready_q, wready_q, bvalid_q;
  logic                  arready_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [ADDR_WIDTH-1:2] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [NB-1:0]         wstrb_q;

  logic                  unused_addr;
  assign unused_addr = ^{s1_axi_awaddr[1:0], s1_axi_araddr[1:0]};

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      full_d[i] = {1'b0, opa_q[i]} + {1'b0, opb_q[i]};
      res_d[i]  = full_d[i][DATA_WIDTH-1:0];
      sts_d[i]  = {1'b0,
                   (opa_q[i][DATA_WIDTH-1] == opb_q[i][DATA_WIDTH-1]) &&
                   (full_d[i][DATA_WIDTH-1] != opa_q[i][DATA_WIDTH-1]),
                   full_d[i][DATA_WIDTH]};
`ifdef AXIL_ADDER_SAT_EN
      if (full_d[i][DATA_WIDTH]) begin
        res_d[i]    = '1;
        sts_d[i][2] = 1'b1;
      end
`endif
    end
  end

  // Write target decode from the captured AW address.
  logic [CW-1:0]     aw_ch;
  logic [1:0]        aw_off;
  logic [NUM_CH-1:0] wr_sel;
  logic              wr_ok;

  assign aw_ch  = awaddr_q[ADDR_WIDTH-1:4];
  assign aw_off = awaddr_q[3:2];

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      wr_sel[i] = (aw_ch == CW'(i));
    wr_ok = (|wr_sel) && !aw_off[1];
  end

  logic [CW-1:0]         ar_ch;
  logic [1:0]            ar_off;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  rd_err;

  assign ar_ch  = s1_axi_araddr[ADDR_WIDTH-1:4];
  assign ar_off = s1_axi_araddr[3:2];

  always_comb begin
    rd_val = '0;
    rd_err = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ar_ch == CW'(i)) begin
        rd_err = 1'b0;
        unique case (ar_off)
          2'd0:    rd_val = opa_q[i];
          2'd1:    rd_val = opb_q[i];
          2'd2:    rd_val = res_q[i];
          default: rd_val = {{(DATA_WIDTH-3){1'b0}}, sts_q[i]};
        endcase
      end
    end
  end

  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        res_q[i] <= '0;
        sts_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        res_q[i] <= res_d[i];
        sts_q[i] <= sts_d[i];
      end
    end
  end

  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      wst_q     <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        opa_q[i] <= '0;
        opb_q[i] <= '0;
      end
    end else begin
      unique case (wst_q)
        W_IDLE: begin
          if (s1_axi_awvalid && awready_q) begin
            awaddr_q  <= s1_axi_awaddr[ADDR_WIDTH-1:2];
            awready_q <= 1'b0;
          end
          if (s1_axi_wvalid && wready_q) begin
            wdata_q  <= s1_axi_wdata;
            wstrb_q  <= s1_axi_wstrb;
            wready_q <= 1'b0;
          end
          if (!awready_q && !wready_q) begin
            for (int i = 0; i < NUM_CH; i++)
              for (int b = 0; b < NB; b++)
                if (wr_ok && wr_sel[i] && wstrb_q[b]) begin
                  if (aw_off[0]) opb_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
                  else           opa_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            bresp_q  <= wr_ok ? OKAY : SLVERR;
            bvalid_q <= 1'b1;
            wst_q    <= W_RESP;
          end
        end
        W_RESP: begin
          if (s1_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wst_q     <= W_IDLE;
          end
        end
        default: wst_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      rst_q     <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      unique case (rst_q)
        R_IDLE: begin
          if (s1_axi_arvalid) begin
            rdata_q   <= rd_val;
            rresp_q   <= rd_err ? SLVERR : OKAY;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rst_q     <= R_DATA;
          end
        end
        R_DATA: begin
          if (s1_axi_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rst_q     <= R_IDLE;
          end
        end
        default: rst_q <= R_IDLE;
      endcase
    end
  end

  assign s1_axi_awready = awready_q;
  assign s1_axi_wready  = wready_q;
  assign s1_axi_bvalid  = bvalid_q;
  assign s1_axi_bresp   = bresp_q;
  assign s1_axi_arready = arready_q;
  assign s1_axi_rvalid  = rvalid_q;
  assign s1_axi_rdata   = rdata_q;
  assign s1_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axil_multi_adder.sv
// Directed bench for axil_multi_adder (NUM_CH=4, 32-bit data, 8-bit address).
// Expected values are hand-computed; SAT variant selected by AXIL_ADDER_SAT_EN.
module tb_axil_multi_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axil_multi_adder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_CH(4)) dut (
    .s1_axi_aclk(clk), .s1_axi_aresetn(rst_n),
    .s1_axi_awaddr(awaddr), .s1_axi_awvalid(awvalid), .s1_axi_awready(awready),
    .s1_axi_wdata(wdata), .s1_axi_wstrb(wstrb),
    .s1_axi_wvalid(wvalid), .s1_axi_wready(wready),
    .s1_axi_bresp(bresp), .s1_axi_bvalid(bvalid), .s1_axi_bready(bready),
    .s1_axi_araddr(araddr), .s1_axi_arvalid(arvalid), .s1_axi_arready(arready),
    .s1_axi_rdata(rdata), .s1_axi_rresp(rresp),
    .s1_axi_rvalid(rvalid), .s1_axi_rready(rready)
  );

  // W is offered `lead` cycles before AW; a timeout leaves resp as X.
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int lead,
                           output logic [1:0] resp);
    bit awd, wd, awh, wh;
    resp = 2'bxx;
    awd = 0;
    wd = 0;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; wvalid = 1'b1;
    for (int c = 0; c < 40 && !(awd && wd); c++) begin
      if (c >= lead && !awd) awvalid = 1'b1;
      awh = awvalid && awready;
      wh  = wvalid && wready;
      @(negedge clk);
      if (awh) begin awvalid = 1'b0; awd = 1; end
      if (wh)  begin wvalid = 1'b0;  wd = 1;  end
    end
    if (awd && wd) begin
      bready = 1'b1;
      for (int c = 0; c < 40; c++) begin
        if (bvalid) begin
          resp = bresp;
          @(negedge clk);
          break;
        end
        @(negedge clk);
      end
    end
    bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    bit h, done;
    d = 'x;
    resp = 2'bxx;
    done = 0;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      h = arvalid && arready;
      @(negedge clk);
      if (h) begin arvalid = 1'b0; done = 1; break; end
    end
    if (done) begin
      rready = 1'b1;
      for (int c = 0; c < 40; c++) begin
        if (rvalid) begin
          d = rdata;
          resp = rresp;
          @(negedge clk);
          break;
        end
        @(negedge clk);
      end
    end
    rready = 1'b0; arvalid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    rst_n = 1'b0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; araddr = '0; arvalid = 0; rready = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (awready !== 1'b1) begin bad++; $display("FAIL rst_awready got=%b exp=1", awready); end
    total++; if (wready !== 1'b1) begin bad++; $display("FAIL rst_wready got=%b exp=1", wready); end
    total++; if (arready !== 1'b1) begin bad++; $display("FAIL rst_arready got=%b exp=1", arready); end
    total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL rst_bvalid got=%b exp=0", bvalid); end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", rvalid); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    total++; if ({bresp, rresp} !== 4'b0) begin bad++; $display("FAIL rst_resp got=%b exp=0000", {bresp, rresp}); end
    axi_read(8'h08, d, r);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_res0 got=%h exp=0", d); end
    total++; if (r !== 2'b00) begin bad++; $display("FAIL rst_res0_resp got=%b exp=00", r); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(8'h10, 32'h5, 4'hF, 3, r);
    total++; if (r !== 2'b00) begin bad++; $display("FAIL basic_wa got=%b exp=00", r); end
    axi_write(8'h14, 32'h7, 4'hF, 0, r);
    total++; if (r !== 2'b00) begin bad++; $display("FAIL basic_wb got=%b exp=00", r); end
    axi_read(8'h18, d, r);
    total++; if (d !== 32'hC || r !== 2'b00) begin bad++; $display("FAIL basic_res got=%h/%b exp=0000000c/00", d, r); end
    axi_read(8'h1C, d, r);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL basic_sts got=%h exp=0", d); end
  endtask

  task automatic test_carry();
    logic [31:0] d, er, es;
    logic [1:0]  r;
`ifdef AXIL_ADDER_SAT_EN
    er = 32'hFFFF_FFFF; es = 32'h5;
`else
    er = 32'h1; es = 32'h1;
`endif
    axi_write(8'h20, 32'hFFFF_FFFF, 4'hF, 0, r);
    axi_write(8'h24, 32'h2, 4'hF, 1, r);
    total++; if (r !== 2'b00) begin bad++; $display("FAIL carry_wr got=%b exp=00", r); end
    axi_read(8'h28, d, r);
    total++; if (d !== er) begin bad++; $display("FAIL carry_res got=%h exp=%h", d, er); end
    axi_read(8'h2C, d, r);
    total++; if (d !== es) begin bad++; $display("FAIL carry_sts got=%h exp=%h", d, es); end
  endtask

  task automatic test_overflow_strobe();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(8'h30, 32'h7FFF_FFFF, 4'hF, 0, r);
    axi_write(8'h34, 32'h1, 4'hF, 0, r);
    axi_read(8'h38, d, r);
    total++; if (d !== 32'h8000_0000) begin bad++; $display("FAIL ovf_res got=%h exp=80000000", d); end
    axi_read(8'h3C, d, r);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL ovf_sts got=%h exp=2", d); end
    axi_write(8'h30, 32'hAABB_CCDD, 4'b0010, 0, r);
    total++; if (r !== 2'b00) begin bad++; $display("FAIL strb_wr got=%b exp=00", r); end
    axi_read(8'h30, d, r);
    total++; if (d !== 32'h7FFF_CCFF) begin bad++; $display("FAIL strb_opa got=%h exp=7fffccff", d); end
    axi_read(8'h38, d, r);
    total++; if (d !== 32'h7FFF_CD00) begin bad++; $display("FAIL strb_res got=%h exp=7fffcd00", d); end
    axi_read(8'h3C, d, r);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL strb_sts got=%h exp=0", d); end
  endtask

  task automatic test_errors();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(8'h40, 32'h1234, 4'hF, 0, r);
    total++; if (r !== 2'b10) begin bad++; $display("FAIL err_wch got=%b exp=10", r); end
    axi_write(8'h08, 32'h1234, 4'hF, 2, r);
    total++; if (r !== 2'b10) begin bad++; $display("FAIL err_wres got=%b exp=10", r); end
    axi_write(8'h0C, 32'h7, 4'hF, 0, r);
    total++; if (r !== 2'b10) begin bad++; $display("FAIL err_wsts got=%b exp=10", r); end
    axi_read(8'h08, d, r);
    total++; if (d !== 32'h0 || r !== 2'b00) begin bad++; $display("FAIL err_res0 got=%h/%b exp=0/00", d, r); end
    axi_read(8'h00, d, r);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL err_opa0 got=%h exp=0", d); end
    axi_read(8'h40, d, r);
    total++; if (d !== 32'h0 || r !== 2'b10) begin bad++; $display("FAIL err_rch got=%h/%b exp=0/10", d, r); end
    axi_write(8'h10, 32'hFFFF_FFFF, 4'h0, 0, r);
    total++; if (r !== 2'b00) begin bad++; $display("FAIL strb0_wr got=%b exp=00", r); end
    axi_read(8'h10, d, r);
    total++; if (d !== 32'h5) begin bad++; $display("FAIL strb0_opa got=%h exp=5", d); end
  endtask

  task automatic test_hold_reset();
    logic [31:0] d;
    logic [1:0]  r;
    @(negedge clk);
    awaddr = 8'h10; wdata = 32'h99; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; bready = 0; rready = 0;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    araddr = 8'h10; arvalid = 1;
    total++; if ({awready, wready} !== 2'b00) begin bad++; $display("FAIL hold_cap got=%b exp=00", {awready, wready}); end
    @(negedge clk);
    arvalid = 0;
    for (int k = 0; k < 5; k++) begin
      total++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin bad++; $display("FAIL hold_b%0d got=%b/%b exp=1/00", k, bvalid, bresp); end
      total++; if (rvalid !== 1'b1 || rdata !== 32'h5) begin bad++; $display("FAIL hold_r%0d got=%b/%h exp=1/5", k, rvalid, rdata); end
      total++; if ({awready, arready} !== 2'b00) begin bad++; $display("FAIL hold_rdy%0d got=%b exp=00", k, {awready, arready}); end
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({bvalid, rvalid} !== 2'b00) begin bad++; $display("FAIL arst_valid got=%b exp=00", {bvalid, rvalid}); end
    total++; if ({awready, wready, arready} !== 3'b111) begin bad++; $display("FAIL arst_rdy got=%b exp=111", {awready, wready, arready}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    axi_read(8'h10, d, r);
    total++; if (d !== 32'h0 || r !== 2'b00) begin bad++; $display("FAIL arst_opa got=%h/%b exp=0/00", d, r); end
    axi_read(8'h38, d, r);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL arst_res got=%h exp=0", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_overflow_strobe();
    test_errors();
    test_hold_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
